// File: rtl/fp_add_arb_pkg.sv
// Shared types and helpers for the fp_add_arbiter block.
//   fp32_t        : IEEE-754 single-precision word
//   FP32_SIGN_BIT : sign bit index of an fp32_t
//   tag_width()   : bits needed to hold a requester index (minimum 1)
package fp_add_arb_pkg;

    typedef logic [31:0] fp32_t;

    localparam int FP32_SIGN_BIT = 31;

    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fp_add_arb_rr.sv
// Round-robin priority picker.
//   req   : request vector, one bit per requester
//   ptr   : index of the most recent grant; search starts at ptr+1
//   grant : one-hot grant (all zero when no request)
module fp_add_arb_rr #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TAG_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin front end that shares one fixed-latency fp32 adder between
// NUM_REQ requesters and routes each result back to its issuer.
// Optional feature macro: FP_ADD_ARB_SUB_EN (flip sign of B when req_sub set).
//   clk, rst_n         : rising-edge clock, async active-low reset
//   req_valid/ready    : per-requester handshake (ready is the grant)
//   req_a, req_b       : per-requester operands
//   req_sub            : per-requester subtract select
//   add_a, add_b       : registered operands to the shared adder
//   add_result         : adder sum, valid LATENCY cycles after add_a/add_b
//   resp_valid         : one-hot, single-cycle result strobe
//   resp_data          : registered result
//   busy               : operation in flight
module fp_add_arbiter
    import fp_add_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0][31:0]  req_a,
    input  logic [NUM_REQ-1:0][31:0]  req_b,
    input  logic [NUM_REQ-1:0]        req_sub,
    output logic [31:0]               add_a,
    output logic [31:0]               add_b,
    input  logic [31:0]               add_result,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [31:0]               resp_data,
    output logic                      busy
);

    localparam int TAG_W = tag_width(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [TAG_W-1:0]   last_grant;
    logic [TAG_W-1:0]   grant_tag;
    logic               handshake;
    fp32_t              sel_a;
    fp32_t              sel_b;

    // iss_* tracks the op whose operands sit in add_a/add_b; the following
    // LATENCY-deep shift register lines its tag up with add_result.
    logic               iss_vld;
    logic [TAG_W-1:0]   iss_tag;
    logic [LATENCY-1:0] sr_vld;
    logic [TAG_W-1:0]   sr_tag [LATENCY];

    fp_add_arb_rr #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (last_grant),
        .grant (grant)
    );

    assign req_ready = rst_n ? grant : '0;
    assign handshake = |(req_valid & req_ready);

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        grant_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_a     = req_a[i];
                sel_b     = req_b[i];
                grant_tag = TAG_W'(i);
`ifdef FP_ADD_ARB_SUB_EN
                sel_b[FP32_SIGN_BIT] = req_b[i][FP32_SIGN_BIT] ^ req_sub[i];
`endif
            end
        end
    end

`ifndef FP_ADD_ARB_SUB_EN
    logic unused_sub;
    assign unused_sub = ^req_sub;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= TAG_W'(NUM_REQ - 1);
            add_a      <= '0;
            add_b      <= '0;
            iss_vld    <= 1'b0;
            iss_tag    <= '0;
            sr_vld     <= '0;
            for (int k = 0; k < LATENCY; k++) sr_tag[k] <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            iss_vld <= handshake;
            iss_tag <= grant_tag;
            if (handshake) begin
                last_grant <= grant_tag;
                add_a      <= sel_a;
                add_b      <= sel_b;
            end
            sr_vld[0] <= iss_vld;
            sr_tag[0] <= iss_tag;
            for (int k = 1; k < LATENCY; k++) begin
                sr_vld[k] <= sr_vld[k-1];
                sr_tag[k] <= sr_tag[k-1];
            end
            resp_valid <= sr_vld[LATENCY-1] ? (NUM_REQ'(1) << sr_tag[LATENCY-1]) : '0;
            if (sr_vld[LATENCY-1]) resp_data <= add_result;
        end
    end

    assign busy = iss_vld | (|sr_vld) | (|resp_valid);

endmodule
